pixel_pack_sender: RTL
======================

# pixel_pack_sender

Transmit side of the pixel-pack link. Accepts a frame of 16-bit pixels one at a time and emits 33-bit `epack` words, two pixels per word plus a frame-start flag, to the downstream collector over a valid/ready handshake. Sits between the pixel source (camera front end / test pattern generator) and the data collector feeding the standard-deviation pipeline. Pulses `frame_done` when the last word of a frame has been accepted.

## Interface
- `PIXELS_PER_FRAME`, default 3392: pixels per frame. Must be even and ≥2; an elaboration-time check rejects any other value.
- `PIX_W`, default 16: pixel width. `epack` width is 2*PIX_W+1.
- `clk` input, 1: the single clock; all logic is rising-edge.
- `rstn` input, 1: reset, asynchronous, active-low.
- `frame_start` input, 1: one-cycle request to begin a frame. Honoured only in IDLE.
- `pix_in` input, PIX_W: pixel data.
- `pix_valid` input, 1: `pix_in` is valid.
- `pix_ready` output, 1: sender accepts a pixel this cycle.
- `epack` output, 2*PIX_W+1: [32] = first word of frame, [31:16] = even-index pixel, [15:0] = odd-index pixel.
- `epack_valid` output, 1: `epack` is valid.
- `epack_ready` input, 1: downstream accepts `epack` this cycle.
- `frame_done` output, 1: one-cycle pulse after the last word is accepted.
- `busy` output, 1: high in every state except IDLE.

## Operation
- States: IDLE, GET_HI, GET_LO, SEND, DONE.
- IDLE: `frame_start`=1 → GET_HI; clear the pair counter; set the first-word flag.
- GET_HI: `pix_ready`=1. On `pix_valid` latch `pix_in` into the hi half → GET_LO.
- GET_LO: `pix_ready`=1. On `pix_valid` latch `pix_in` into the lo half → SEND.
- SEND: `epack_valid`=1, `pix_ready`=0. On `epack_ready`: clear the first-word flag. If the pair counter equals PIXELS_PER_FRAME/2-1 → DONE, else increment the counter → GET_HI.
- DONE: `frame_done`=1 for exactly one cycle → IDLE.
- Pair counter width is $clog2(PIXELS_PER_FRAME/2), so 11 bits at the default. It never wraps within a frame.
- `epack[32]`=1 only on word 0 of each frame.
- `frame_start` outside IDLE is ignored. It is not queued.
- `pix_valid` in IDLE, SEND or DONE is not consumed. The source holds its data.
- Unused state encodings → IDLE.

## Timing
- Reset values: `pix_ready`=0, `epack`=0, `epack_valid`=0, `frame_done`=0, `busy`=0, state=IDLE, counter=0.
- Outputs are decoded from the registered state and data registers. There is no combinational path from `epack_ready` or `pix_valid` to any output.
- `frame_start` sampled at edge N → `pix_ready`=1 from cycle N+1.
- Second pixel accepted at edge N → `epack_valid`=1 in cycle N+1.
- Word accepted at edge M (`epack_valid`&&`epack_ready`) → `epack_valid`=0 and `pix_ready`=1 in cycle M+1, or `frame_done`=1 in cycle M+1 for the last word.
- While `epack_valid`=1 and `epack_ready`=0, `epack` is held stable indefinitely.
- Peak rate: one word per 3 cycles. One frame at the default parameter size is 1696 words.
- `rstn` low mid-frame: immediate return to reset values. The partial word and pair count are discarded, and no `frame_done` is issued.
- `frame_start` in the DONE cycle is ignored. The earliest new frame starts from IDLE on the following cycle.

## Structure
- Shared package `pixel_pkg` holds:
  - localparams `PIXELS_PER_FRAME`=3392, `PIX_W`=16, `EPACK_W`=33, `EPACK_SOF_BIT`=32;
  - the state enum typedef `sender_state_t`.
- The data collector imports `pixel_pkg` so both ends agree on the word layout.
- Single module; no sub-module is warranted.

## Test plan
- Basic frame with PIXELS_PER_FRAME=4, pixels 0x1111, 0x2222, 0x3333, 0x4444, `epack_ready` tied 1 → words 0x1_1111_2222 then 0x0_3333_4444, then one `frame_done` pulse, then `busy`=0.
- Backpressure: hold `epack_ready`=0 for 5 cycles in SEND → `epack` stable, `epack_valid`=1 and `pix_ready`=0 throughout; the word is accepted on the first ready cycle.
- Default size with random `pix_valid`/`epack_ready`, pixel i = i → exactly 1696 words, word k = {k==0, 2k, 2k+1}, `frame_done` after word 1695.
- `frame_start` pulsed in GET_LO, in SEND and in the DONE cycle → no restart, counter unaffected, exactly one frame produced.
- `rstn` asserted after 3 words → all outputs at reset values within the same cycle, no `frame_done`. The next frame starts with `epack[32]`=1.
- `pix_valid`=1 while IDLE for 10 cycles without `frame_start` → `pix_ready`=0 and no `epack_valid`.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel-pack link, imported by both the sender and the collector
// so the two ends agree on the epack word layout.
package pixel_pkg;

   localparam int PIXELS_PER_FRAME = 3392;
   localparam int PIX_W            = 16;
   localparam int EPACK_W          = 2 * PIX_W + 1;
   localparam int EPACK_SOF_BIT    = 2 * PIX_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GET_HI = 3'd1,
      S_GET_LO = 3'd2,
      S_SEND   = 3'd3,
      S_DONE   = 3'd4
   } sender_state_t;

endpackage

// File: rtl/pixel_pack_sender.sv
// Packs a frame of pixels two at a time into {sof, even, odd} words and hands them downstream
// over valid/ready; every output is a register so nothing downstream sees input-to-output paths.
module pixel_pack_sender #(
   parameter int PIXELS_PER_FRAME = pixel_pkg::PIXELS_PER_FRAME,
   parameter int PIX_W            = pixel_pkg::PIX_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               frame_start,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   output logic               pix_ready,
   output logic [2*PIX_W:0]   epack,
   output logic               epack_valid,
   input  logic               epack_ready,
   output logic               frame_done,
   output logic               busy
);
   import pixel_pkg::*;

   localparam int PAIRS = PIXELS_PER_FRAME / 2;
   localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

   if ((PIXELS_PER_FRAME < 2) || ((PIXELS_PER_FRAME % 2) != 0)) begin : g_bad_frame_size
      $error("pixel_pack_sender: PIXELS_PER_FRAME must be even and at least 2");
   end

   sender_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [PIX_W-1:0] hi_q, hi_d;
   logic [PIX_W-1:0] lo_q, lo_d;
   logic             pix_ready_q;
   logic             epack_valid_q;
   logic             frame_done_q;
   logic             busy_q;

   // Next-state and datapath update for the pack sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_GET_HI;
               cnt_d   = '0;
               first_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GET_HI: begin
            if (pix_valid) begin
               hi_d    = pix_in;
               state_d = S_GET_LO;
            end else begin
               state_d = S_GET_HI;
            end
         end
         S_GET_LO: begin
            if (pix_valid) begin
               lo_d    = pix_in;
               state_d = S_SEND;
            end else begin
               state_d = S_GET_LO;
            end
         end
         S_SEND: begin
            if (epack_ready) begin
               first_d = 1'b0;
               if (cnt_q == LAST_PAIR) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = S_GET_HI;
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, data and output registers; outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         first_q       <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         pix_ready_q   <= 1'b0;
         epack_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         first_q       <= first_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         pix_ready_q   <= (state_d == S_GET_HI) || (state_d == S_GET_LO);
         epack_valid_q <= (state_d == S_SEND);
         frame_done_q  <= (state_d == S_DONE);
         busy_q        <= (state_d != S_IDLE);
      end
   end

   assign pix_ready   = pix_ready_q;
   assign epack       = {first_q, hi_q, lo_q};
   assign epack_valid = epack_valid_q;
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;

endmodule
